// File: rtl/isa_pkg.sv
// Shared ISA constants, retire-entry layout and PC-continuity helpers
// for the retirement trace queue.
package isa_pkg;

  localparam logic [31:0] PC_INIT = 32'h0000_0200;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [15:0] seq;
  } entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] inst);
    return (inst[1:0] == 2'b11) ? pc + 32'd4 : pc + 32'd2;
  endfunction

  // True when the successor PC is not simply sequential, so it cannot be checked.
  function automatic logic breaks_flow(input logic [31:0] inst);
    logic [2:0] f3;
    f3 = inst[15:13];
    case (inst[1:0])
      2'b01:   return (f3 == 3'b001) || (f3 == 3'b101) || (f3 == 3'b110) || (f3 == 3'b111);
      2'b10:   return (f3 == 3'b100) && (inst[6:2] == 5'd0);
      2'b11:   return (inst[6:0] == OP_BRANCH) || (inst[6:0] == OP_JAL) ||
                      (inst[6:0] == OP_JALR)   || (inst[6:0] == OP_SYSTEM);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/retire_fifo.sv
// Circular buffer of retire entries with occupancy count; a push at full
// is accepted only when a pop frees a slot in the same cycle.
module retire_fifo
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_req,
  input  entry_t                   wr_entry,
  input  logic                     pop_req,
  output logic                     valid,
  output entry_t                   rd_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            pop;
  logic            push;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = valid && pop_req;
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  // Empty queue presents zeros so the outputs read zero throughout reset.
  assign rd_entry = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/retire_queue.sv
// Retirement trace queue: buffers retiring instructions with a sequence
// number and flags dropped entries and PC-continuity violations.
module retire_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] PC_INIT = isa_pkg::PC_INIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid_i,
  input  logic [31:0]            wb_pc_i,
  input  logic [31:0]            wb_inst_i,
  input  logic                   ret_ready_i,
  output logic                   ret_valid_o,
  output logic [31:0]            ret_pc_o,
  output logic [31:0]            ret_inst_o,
  output logic [15:0]            ret_seq_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   pc_err_o
);

  import isa_pkg::*;

  logic [15:0] seq_cnt;
  logic [31:0] exp_pc;
  logic        chk_en;
  logic        drop;
  entry_t      wr_entry;
  entry_t      rd_entry;

  assign wr_entry = '{pc: wb_pc_i, inst: wb_inst_i, seq: seq_cnt};

  retire_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_req (wb_valid_i),
    .wr_entry (wr_entry),
    .pop_req  (ret_ready_i),
    .valid    (ret_valid_o),
    .rd_entry (rd_entry),
    .count    (count_o),
    .drop     (drop)
  );

  assign ret_pc_o   = rd_entry.pc;
  assign ret_inst_o = rd_entry.inst;
  assign ret_seq_o  = rd_entry.seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt    <= '0;
      exp_pc     <= PC_INIT;
      chk_en     <= 1'b1;
      overflow_o <= 1'b0;
      pc_err_o   <= 1'b0;
    end else begin
      if (drop) overflow_o <= 1'b1;
      if (wb_valid_i) begin
        seq_cnt <= seq_cnt + 16'd1;
        exp_pc  <= next_pc(wb_pc_i, wb_inst_i);
        chk_en  <= !breaks_flow(wb_inst_i);
        if (chk_en && (wb_pc_i != exp_pc)) pc_err_o <= 1'b1;
      end
    end
  end

endmodule
